// File: rtl/accumulator_deskew.sv
// Deskew + accumulate stage behind the MAC systolic array: realigns skewed row
// outputs, overwrites/accumulates them into an entry bank, and serves a 1-cycle read port.

module accumulator_deskew_lane #(
  parameter int W   = 32,
  parameter int DLY = 1
) (
  input  logic         clk_i,
  input  logic [W-1:0] din_i,
  input  logic [W-1:0] old_i,
  input  logic         acc_i,
  output logic [W-1:0] new_o
);
  // DLY registers: lane r arrives r cycles late, so it needs ROWS-r stages to
  // line up with the write stage.
  logic [DLY-1:0][W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = din_i;
    for (int i = 1; i < DLY; i++) sr_d[i] = sr_q[i-1];
  end

  always_ff @(posedge clk_i) sr_q <= sr_d;

  assign new_o = acc_i ? (old_i + sr_q[DLY-1]) : sr_q[DLY-1];
endmodule

module accumulator_deskew #(
  parameter int ROWS  = 32,
  parameter int ACC_W = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [AW-1:0]         cmd_addr_i,
  input  logic [AW:0]           cmd_len_i,
  input  logic                  cmd_acc_i,
  input  logic                  in_valid_i,
  input  logic [ROWS*ACC_W-1:0] in_data_i,
  input  logic                  rd_en_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic                  rd_valid_o,
  output logic [ROWS*ACC_W-1:0] rd_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef logic [ROWS-1:0][ACC_W-1:0] vec_t;

  logic [1:0]    state_q, state_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          acc_q, acc_d;
  logic          err_q, err_d;
  logic [ROWS:1] vld_pipe_q, vld_pipe_d;
  logic [ROWS:1] last_pipe_q, last_pipe_d;
  logic          rd_valid_q, rd_valid_d;
  vec_t          rd_data_q, rd_data_d;

  vec_t          mem_q [DEPTH];
  vec_t          wr_old, wr_vec;
  logic          in_take, in_last, wr_en, wr_last;

  assign in_take = in_valid_i && (state_q == S_ACTIVE);
  assign in_last = in_take && (rem_q == (AW+1)'(1));
  assign wr_en   = vld_pipe_q[ROWS];
  assign wr_last = last_pipe_q[ROWS];
  assign wr_old  = mem_q[wr_ptr_q];

  // Valid and last-vector markers ride alongside lane 0 through the deskew.
  always_comb begin
    vld_pipe_d  = {vld_pipe_q[ROWS-1:1], in_take};
    last_pipe_d = {last_pipe_q[ROWS-1:1], in_last};
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    wr_ptr_d = wr_ptr_q;
    acc_d    = acc_q;
    err_d    = err_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          wr_ptr_d = cmd_addr_i;
          rem_d    = cmd_len_i;
          acc_d    = cmd_acc_i;
          err_d    = 1'b0;
          state_d  = (cmd_len_i == '0) ? S_DONE : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (in_valid_i) begin
          rem_d = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wr_en && wr_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (in_valid_i && (state_q != S_ACTIVE)) err_d = 1'b1;
  end

  always_comb begin
    rd_valid_d = rd_en_i;
    rd_data_d  = rd_en_i ? mem_q[rd_addr_i] : rd_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      wr_ptr_q    <= '0;
      acc_q       <= 1'b0;
      err_q       <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      wr_ptr_q    <= wr_ptr_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Entry bank keeps its contents across reset; a cleared valid pipe is what
  // stops abandoned vectors from landing.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_vec;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    accumulator_deskew_lane #(
      .W   (ACC_W),
      .DLY (ROWS - r)
    ) u_lane (
      .clk_i (clk_i),
      .din_i (in_data_i[r*ACC_W +: ACC_W]),
      .old_i (wr_old[r]),
      .acc_i (acc_q),
      .new_o (wr_vec[r])
    );
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
endmodule

// File: tb/tb_accumulator_deskew.sv
// Directed bench for accumulator_deskew: skewed lane driver, read-back table,
// and hand-written sequences for done timing, errors and mid-command reset.

module tb_accumulator_deskew;
  localparam int ROWS  = 32;
  localparam int ACC_W = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int VW    = ROWS*ACC_W;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i;
  logic [AW:0]   cmd_len_i;
  logic          cmd_acc_i;
  logic          in_valid_i;
  logic [VW-1:0] in_data_i;
  logic          rd_en_i;
  logic [AW-1:0] rd_addr_i;
  logic          rd_valid_o;
  logic [VW-1:0] rd_data_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  accumulator_deskew #(.ROWS(ROWS), .ACC_W(ACC_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_acc_i(cmd_acc_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          phase;
    logic [AW-1:0] addr;
    logic [31:0] base;
    logic [31:0] step;
  } rd_rec_t;

  rd_rec_t     tbl [18];
  logic [31:0] vd [4][ROWS];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, done_cnt = 0, exp_done = 0, t_last = 0;

  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) if (done_o === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [VW-1:0] act, input logic [31:0] base,
                      input logic [31:0] step);
    int bad = -1;
    logic [31:0] e;
    n_chk++;
    for (int r = ROWS-1; r >= 0; r--) begin
      e = base + step * r;
      if (act[r*ACC_W +: ACC_W] !== e) bad = r;
    end
    if (bad >= 0) begin
      n_fail++;
      e = base + step * bad;
      $display("FAIL %s: lane %0d got %h expected %h", nm, bad, act[bad*ACC_W +: ACC_W], e);
    end
  endtask

  task automatic issue_cmd(input logic [AW-1:0] a, input int len, input logic acc,
                           output int acyc);
    cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_len_i = (AW+1)'(len); cmd_acc_i = acc;
    chk("cmd_ready_idle", cmd_ready_o, 1'b1);
    acyc = cyc;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic fill(input int n, input logic [31:0] val, input logic [31:0] step);
    for (int k = 0; k < n; k++)
      for (int r = 0; r < ROWS; r++) vd[k][r] = val + step * r;
  endtask

  // Drives n vectors skewed across lanes for ncyc cycles.
  task automatic send(input int n, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      in_valid_i = (c < n);
      for (int r = 0; r < ROWS; r++) begin
        int k;
        k = c - r;
        in_data_i[r*ACC_W +: ACC_W] = (k >= 0 && k < n) ? vd[k][r] : 32'h0;
      end
      if (c == n-1) t_last = cyc;
      tick();
    end
    in_valid_i = 1'b0;
    in_data_i  = '0;
  endtask

  task automatic wait_done(input int exp_cyc, input string nm);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (done_o === 1'b1) begin
        seen = 1;
        exp_done++;
        chk({nm, "_done_cyc"}, cyc, exp_cyc);
        chk({nm, "_busy_at_done"}, busy_o, 1'b0);
        chk({nm, "_ready_at_done"}, cmd_ready_o, 1'b0);
      end
      tick();
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s: done_o never seen, expected at cycle %0d", nm, exp_cyc);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [VW-1:0] d);
    rd_en_i = 1'b1; rd_addr_i = a;
    tick();
    rd_en_i = 1'b0;
    d = rd_data_o;
    chk("rd_valid", rd_valid_o, 1'b1);
  endtask

  task automatic check_phase(input int p);
    logic [VW-1:0] d;
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].phase == p) begin
        rd(tbl[i].addr, d);
        chkv($sformatf("p%0d_entry%0d", p, tbl[i].addr), d, tbl[i].base, tbl[i].step);
      end
    end
  endtask

  initial begin
    int ac;
    tbl[0]  = '{1, 6'd5,  32'd1,   32'd1};
    tbl[1]  = '{2, 6'd0,  32'd107, 32'd0};
    tbl[2]  = '{2, 6'd1,  32'd107, 32'd0};
    tbl[3]  = '{2, 6'd2,  32'd107, 32'd0};
    tbl[4]  = '{2, 6'd3,  32'd107, 32'd0};
    tbl[5]  = '{3, 6'd62, 32'd1,   32'd0};
    tbl[6]  = '{3, 6'd63, 32'd1,   32'd0};
    tbl[7]  = '{3, 6'd0,  32'd1,   32'd0};
    tbl[8]  = '{3, 6'd1,  32'd1,   32'd0};
    tbl[9]  = '{3, 6'd2,  32'd107, 32'd0};
    tbl[10] = '{4, 6'd5,  32'd1,   32'd1};
    tbl[11] = '{4, 6'd20, 32'h55,  32'd0};
    tbl[12] = '{4, 6'd2,  32'd107, 32'd0};
    tbl[13] = '{5, 6'd40, 32'h11,  32'd0};
    tbl[14] = '{5, 6'd41, 32'h11,  32'd0};
    tbl[15] = '{5, 6'd43, 32'h11,  32'd0};
    tbl[16] = '{6, 6'd40, 32'h12,  32'd0};
    tbl[17] = '{6, 6'd42, 32'h11,  32'd0};

    rst_i = 1'b1; cmd_valid_i = 0; cmd_addr_i = '0; cmd_len_i = '0; cmd_acc_i = 0;
    in_valid_i = 0; in_data_i = '0; rd_en_i = 0; rd_addr_i = '0;
    #3 rst_i = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_rd_valid", rd_valid_o, 1'b0);
    chkv("rst_rd_data", rd_data_o, 32'h0, 32'h0);
    tick(); tick();
    #3 rst_i = 1'b1;
    tick();

    // single overwrite vector, lane r = r+1
    issue_cmd(6'd5, 1, 1'b0, ac);
    fill(1, 32'd1, 32'd1);
    send(1, 1 + ROWS - 1);
    wait_done(t_last + ROWS + 1, "t2");
    tick(); tick();
    chk("t2_done_pulses", done_cnt, exp_done);
    check_phase(1);

    // prefill then streamed accumulate
    issue_cmd(6'd0, 4, 1'b0, ac);
    fill(4, 32'd100, 32'd0);
    send(4, 4 + ROWS - 1);
    wait_done(t_last + ROWS + 1, "t3_pre");
    issue_cmd(6'd0, 4, 1'b1, ac);
    chk("t3_busy_active", busy_o, 1'b1);
    fill(4, 32'd7, 32'd0);
    send(4, 4 + ROWS - 1);
    wait_done(t_last + ROWS + 1, "t3");
    check_phase(2);

    // wrap past DEPTH-1 with modular overflow
    issue_cmd(6'd62, 4, 1'b0, ac);
    fill(4, 32'hFFFF_FFFF, 32'd0);
    send(4, 4 + ROWS - 1);
    wait_done(t_last + ROWS + 1, "t4_pre");
    issue_cmd(6'd62, 4, 1'b1, ac);
    fill(4, 32'd2, 32'd0);
    send(4, 4 + ROWS - 1);
    wait_done(t_last + ROWS + 1, "t4");
    check_phase(3);

    // stray in_valid in IDLE
    for (int r = 0; r < ROWS; r++) in_data_i[r*ACC_W +: ACC_W] = 32'hDEAD_0000 + r;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("t5_err_set", err_o, 1'b1);
    repeat (ROWS + 4) tick();
    in_data_i = '0;
    chk("t5_err_sticky", err_o, 1'b1);
    chk("t5_no_done", done_cnt, exp_done);
    // zero-length command
    issue_cmd(6'd10, 0, 1'b0, ac);
    chk("t5_err_clr", err_o, 1'b0);
    wait_done(ac + 1, "t5_len0");
    // command while busy must not be taken
    issue_cmd(6'd20, 1, 1'b0, ac);
    cmd_valid_i = 1'b1; cmd_addr_i = 6'd5; cmd_len_i = 7'd1; cmd_acc_i = 1'b1;
    chk("t5_ready_busy", cmd_ready_o, 1'b0);
    tick();
    cmd_valid_i = 1'b0;
    fill(1, 32'h55, 32'd0);
    send(1, 1 + ROWS - 1);
    wait_done(t_last + ROWS + 1, "t5");
    check_phase(4);

    // reset mid-command
    issue_cmd(6'd40, 4, 1'b0, ac);
    fill(4, 32'h11, 32'd0);
    send(4, 4 + ROWS - 1);
    wait_done(t_last + ROWS + 1, "t6_pre");
    check_phase(5);
    issue_cmd(6'd40, 4, 1'b0, ac);
    fill(2, 32'h99, 32'd0);
    send(2, 6);
    chk("t6_busy_pre", busy_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    chk("t6_rst_busy", busy_o, 1'b0);
    chk("t6_rst_ready", cmd_ready_o, 1'b1);
    chk("t6_rst_done", done_o, 1'b0);
    chk("t6_rst_err", err_o, 1'b0);
    chkv("t6_rst_rd_data", rd_data_o, 32'h0, 32'h0);
    tick(); tick();
    #3 rst_i = 1'b1;
    tick();
    repeat (ROWS + 8) tick();
    chk("t6_no_done", done_cnt, exp_done);
    check_phase(5);
    issue_cmd(6'd40, 2, 1'b1, ac);
    fill(2, 32'd1, 32'd0);
    send(2, 2 + ROWS - 1);
    wait_done(t_last + ROWS + 1, "t6_post");
    check_phase(6);
    tick(); tick();
    chk("final_done_pulses", done_cnt, exp_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
